// File: rtl/store_merge_ctrl_if.sv
// Store request / word-memory bundle between the control unit, the store merger and data memory.
interface store_merge_ctrl_if;
   logic        start;
   logic [1:0]  store_type;
   logic [31:0] addr;
   logic [31:0] reg_data;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic        busy;
   logic        done;
   logic        align_err;

   modport slave (
      input  start, store_type, addr, reg_data, mem_rdata,
      output mem_addr, mem_wdata, mem_wr, busy, done, align_err
   );

   modport master (
      output start, store_type, addr, reg_data, mem_rdata,
      input  mem_addr, mem_wdata, mem_wr, busy, done, align_err
   );
endinterface

// File: rtl/store_merge_ctrl.sv
// Store-path controller: direct word writes, read-modify-write for sh/sb, rejection of bad stores.
// Outputs are registered and decoded from the next state, so they line up with the state register.
module store_merge_ctrl (
   input  logic              clk,
   input  logic              reset,
   store_merge_ctrl_if.slave bus
);

   localparam int unsigned W = 32;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;

   localparam logic [1:0] T_SW = 2'b00;
   localparam logic [1:0] T_SH = 2'b01;
   localparam logic [1:0] T_SB = 2'b10;
   localparam logic [1:0] T_XX = 2'b11;

   logic [2:0]   state_q, state_d;
   logic [1:0]   type_q, type_d;
   logic [W-1:0] addr_q, addr_d;
   logic [W-1:0] data_q, data_d;
   logic [W-1:0] word_q, word_d;

   logic [W-1:0] mem_addr_q, mem_addr_d;
   logic [W-1:0] mem_wdata_q, mem_wdata_d;
   logic         mem_wr_q, mem_wr_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         align_err_q, align_err_d;

   logic         req_err;

   // Replace one little-endian lane of the old word; sw takes the store data whole.
   function automatic logic [W-1:0] merge_lane(input logic [1:0]   st,
                                                input logic [1:0]   off,
                                                input logic [W-1:0] word,
                                                input logic [W-1:0] data);
      logic [W-1:0] m;
      m = word;
      case (st)
         T_SH: begin
            if (off[1]) m[31:16] = data[15:0];
            else        m[15:0]  = data[15:0];
         end
         T_SB: begin
            case (off)
               2'd0:    m[7:0]   = data[7:0];
               2'd1:    m[15:8]  = data[7:0];
               2'd2:    m[23:16] = data[7:0];
               default: m[31:24] = data[7:0];
            endcase
         end
         default: m = data;
      endcase
      return m;
   endfunction

   assign req_err = (bus.store_type == T_XX) ||
                    ((bus.store_type == T_SW) && (bus.addr[1:0] != 2'b00)) ||
                    ((bus.store_type == T_SH) && bus.addr[0]);

   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      addr_d      = addr_q;
      data_d      = data_q;
      word_d      = word_q;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_wr_d    = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      align_err_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               type_d = bus.store_type;
               addr_d = bus.addr;
               data_d = bus.reg_data;
               if (req_err)                      state_d = S_ERR;
               else if (bus.store_type == T_SW)  state_d = S_WRITE;
               else                              state_d = S_READ;
            end
         end
         S_READ:  state_d = S_WAIT;
         S_WAIT: begin
            word_d  = bus.mem_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Output image of the state being entered.
      case (state_d)
         S_READ, S_WAIT: begin
            mem_addr_d = {addr_d[W-1:2], 2'b00};
            busy_d     = 1'b1;
         end
         S_WRITE: begin
            mem_addr_d  = {addr_d[W-1:2], 2'b00};
            mem_wdata_d = merge_lane(type_d, addr_d[1:0], word_d, data_d);
            mem_wr_d    = 1'b1;
            busy_d      = 1'b1;
         end
         S_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         S_ERR:   align_err_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         type_q      <= T_SW;
         addr_q      <= '0;
         data_q      <= '0;
         word_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         word_q      <= word_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         align_err_q <= align_err_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.align_err = align_err_q;

endmodule
